// File: rtl/jam_pkg.sv
// Shared types and width helpers for the exhaustive job-assignment solver.
package jam_pkg;
  localparam int MAX_N  = 8;
  localparam int MAX_IW = 3;

  typedef enum logic [3:0] {
    IDLE, LOAD, READ, CHECK, PIVOT, SUCC, SWAP, FLIP, DONE
  } state_t;

  // Largest permutation the solver supports; entry k is the job given to worker k.
  typedef logic [MAX_IW-1:0] perm_t [MAX_N];

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int sum_w(input int n, input int cw);
    return cw + $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/jam_perm_next.sv
// Permutation register file plus a multi-cycle lexicographic next-permutation engine,
// sequenced by the solver FSM through the phase input.
module jam_perm_next
  import jam_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = idx_w(N)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load_identity,
  input  logic          step,
  input  state_t        phase,
  output logic [IW-1:0] perm [N],
  output logic          hit,
  output logic          done_step,
  output logic          last
);
  logic [IW-1:0] i_q, j_q, lo_q, hi_q;
  logic          pivot_hit, succ_hit;

  assign pivot_hit = perm[i_q] < perm[i_q + IW'(1)];
  // The suffix right of the pivot is descending, so the rightmost larger entry is the smallest one.
  assign succ_hit  = perm[j_q] > perm[i_q];
  assign hit       = (phase == SUCC) ? succ_hit : pivot_hit;
  assign last      = (i_q == '0) && !pivot_hit;
  assign done_step = !(lo_q < hi_q);

  always_ff @(posedge CLK) begin
    // NOTE: the permutation registers are few and must restart at identity, so they are reset like any flop.
    if (RST || load_identity) begin
      for (int k = 0; k < N; k++) perm[k] <= IW'(k);
      i_q  <= IW'(N-2);
      j_q  <= IW'(N-1);
      lo_q <= '0;
      hi_q <= '0;
    end else if (step) begin
      case (phase)
        PIVOT: begin
          if (pivot_hit) begin
            j_q  <= IW'(N-1);
            lo_q <= i_q + IW'(1);
            hi_q <= IW'(N-1);
          end else if (i_q != '0) begin
            i_q <= i_q - IW'(1);
          end
        end
        SUCC: if (!succ_hit) j_q <= j_q - IW'(1);
        SWAP: begin
          perm[i_q] <= perm[j_q];
          perm[j_q] <= perm[i_q];
        end
        FLIP: begin
          if (lo_q < hi_q) begin
            perm[lo_q] <= perm[hi_q];
            perm[hi_q] <= perm[lo_q];
            lo_q       <= lo_q + IW'(1);
            hi_q       <= hi_q - IW'(1);
          end else begin
            i_q <= IW'(N-2);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/jam_param_solver.sv
// Exhaustive N x N assignment solver: walks all permutations in lexicographic order,
// sums table costs and keeps the minimum, its multiplicity and the first optimal permutation.
module jam_param_solver
  import jam_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int CW    = 7,
  parameter  int MCW   = 16,
  parameter  int PRUNE = 0,
  localparam int IW    = idx_w(N),
  localparam int SW    = sum_w(N, CW)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  output logic [IW-1:0]   W,
  output logic [IW-1:0]   J,
  input  logic [CW-1:0]   Cost,
  output logic            busy,
  output logic            Valid,
  output logic [SW-1:0]   MinCost,
  output logic [MCW-1:0]  MatchCount,
  output logic [N*IW-1:0] BestAssign
);
  state_t          state;
  logic [IW-1:0]   w_q;
  logic [SW-1:0]   sum_q, sum_next;
  logic [IW-1:0]   perm [N];
  logic [N*IW-1:0] perm_flat;
  logic            pn_hit, pn_done, pn_last, prune_hit;

  jam_perm_next #(.N(N)) u_perm (
    .CLK           (CLK),
    .RST           (RST),
    .load_identity (state == IDLE && start),
    .step          (state inside {PIVOT, SUCC, SWAP, FLIP}),
    .phase         (state),
    .perm          (perm),
    .hit           (pn_hit),
    .done_step     (pn_done),
    .last          (pn_last)
  );

  assign sum_next  = sum_q + SW'(Cost);
  // Strictly greater only: equal partial sums must still reach CHECK to be counted.
  assign prune_hit = (PRUNE != 0) && (sum_next > MinCost);
  assign W         = (state == READ) ? w_q : '0;
  assign J         = (state == READ) ? perm[w_q] : perm[0];

  always_comb begin
    // NOTE: default first so the loop below cannot infer a latch.
    perm_flat = '0;
    for (int k = 0; k < N; k++) perm_flat[k*IW +: IW] = perm[k];
  end

  always_ff @(posedge CLK) begin
    // NOTE: state is updated with <= so every branch sees the pre-edge values.
    if (RST) begin
      state      <= IDLE;
      w_q        <= '0;
      sum_q      <= '0;
      busy       <= 1'b0;
      Valid      <= 1'b0;
      MinCost    <= '1;
      MatchCount <= '0;
      BestAssign <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state      <= LOAD;
          busy       <= 1'b1;
          Valid      <= 1'b0;
          MinCost    <= '1;
          MatchCount <= '0;
        end
        LOAD: begin
          state <= READ;
          w_q   <= '0;
          sum_q <= '0;
        end
        READ: begin
          if (prune_hit) begin
            state <= PIVOT;
            w_q   <= '0;
            sum_q <= '0;
          end else begin
            sum_q <= sum_next;
            if (w_q == IW'(N-1)) begin
              state <= CHECK;
              w_q   <= '0;
            end else begin
              w_q <= w_q + IW'(1);
            end
          end
        end
        CHECK: begin
          if (sum_q < MinCost) begin
            MinCost    <= sum_q;
            MatchCount <= MCW'(1);
            BestAssign <= perm_flat;
          end else if (sum_q == MinCost && MatchCount != '1) begin
            MatchCount <= MatchCount + MCW'(1);
          end
          sum_q <= '0;
          state <= PIVOT;
        end
        PIVOT: begin
          if (pn_hit) begin
            state <= SUCC;
          end else if (pn_last) begin
            state <= DONE;
            busy  <= 1'b0;
            Valid <= 1'b1;
          end
        end
        SUCC:    if (pn_hit) state <= SWAP;
        SWAP:    state <= FLIP;
        FLIP:    if (pn_done) state <= READ;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jam_param_solver.sv
// Scoreboard bench: several solver instances with different shapes run on one clock;
// expectations are queued at start and checked when each Valid rises.
module tb_jam_param_solver;
  import jam_pkg::*;

  localparam int NDUT = 7;
  localparam int CWB  = 7;

  typedef struct {
    logic [63:0] min_cost;
    logic [63:0] count;
    logic [63:0] best;
  } exp_t;

  function automatic int n_of(input int g);
    int r;
    case (g)
      0:       r = 4;
      1:       r = 3;
      2:       r = 2;
      default: r = 6;
    endcase
    return r;
  endfunction

  function automatic int mcw_of(input int g);
    return (g == 4) ? 8 : 16;
  endfunction

  function automatic int prune_of(input int g);
    return (g == 6) ? 1 : 0;
  endfunction

  function automatic int cost_fn(input int g, input int w, input int j);
    int r;
    case (g)
      0:       r = (w == j) ? 0 : 10;
      1:       r = w * j;
      2:       r = (w == 0) ? ((j == 0) ? 5 : 3) : ((j == 0) ? 2 : 9);
      3, 4:    r = 1;
      default: r = (w * 37 + j * 11 + w * j * 7 + 5) % 100;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] all_ones(input int g);
    return (64'd1 << sum_w(n_of(g), CWB)) - 64'd1;
  endfunction

  function automatic exp_t mk(input longint m, input longint c, input longint b);
    exp_t e;
    e.min_cost = 64'(m);
    e.count    = 64'(c);
    e.best     = 64'(b);
    return e;
  endfunction

  // Reference: counts through all N^N index tuples in ascending order (worker 0 most
  // significant) and keeps only those with distinct jobs, i.e. lexicographic permutation order.
  function automatic exp_t model(input int g);
    exp_t   e;
    int     n, iw, total, min_s;
    longint cnt, sat;
    n = n_of(g); iw = idx_w(n); total = 1; min_s = 1 << 30; cnt = 0;
    e = mk(0, 0, 0);
    for (int k = 0; k < n; k++) total = total * n;
    for (int t = 0; t < total; t++) begin
      perm_t            p;
      logic [MAX_N-1:0] used;
      bit               ok;
      int               rem, s;
      rem = t; used = '0; ok = 1'b1; s = 0;
      for (int k = 0; k < MAX_N; k++) p[k] = '0;
      for (int k = n - 1; k >= 0; k--) begin
        p[k] = MAX_IW'(rem % n);
        rem  = rem / n;
      end
      for (int k = 0; k < n; k++) begin
        if (used[p[k]]) ok = 1'b0;
        used[p[k]] = 1'b1;
        s = s + cost_fn(g, k, int'(p[k]));
      end
      if (ok) begin
        if (s < min_s) begin
          min_s = s; cnt = 1; e.best = '0;
          for (int k = 0; k < n; k++) e.best = e.best | (64'(p[k]) << (k * iw));
        end else if (s == min_s) begin
          cnt = cnt + 1;
        end
      end
    end
    sat = (longint'(1) << mcw_of(g)) - 1;
    if (cnt > sat) cnt = sat;
    e.min_cost = 64'(min_s);
    e.count    = 64'(cnt);
    return e;
  endfunction

  logic        CLK, RST;
  logic        start_v [NDUT];
  logic [63:0] w_v [NDUT], j_v [NDUT], min_v [NDUT], cnt_v [NDUT], best_v [NDUT];
  logic        busy_v [NDUT], valid_v [NDUT];

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   start_cyc [NDUT];
  int   done_cyc [NDUT];
  exp_t exp_q [NDUT][$];

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    localparam int GN   = n_of(g);
    localparam int GIW  = idx_w(GN);
    localparam int GSW  = sum_w(GN, CWB);
    localparam int GMCW = mcw_of(g);
    logic [GIW-1:0]    w_s, j_s;
    logic [CWB-1:0]    cost_s;
    logic [GSW-1:0]    min_s;
    logic [GMCW-1:0]   cnt_s;
    logic [GN*GIW-1:0] best_s;
    logic              busy_s, valid_s;

    assign cost_s = CWB'(cost_fn(g, int'(w_s), int'(j_s)));

    jam_param_solver #(.N(GN), .CW(CWB), .MCW(GMCW), .PRUNE(prune_of(g))) u_dut (
      .CLK        (CLK),
      .RST        (RST),
      .start      (start_v[g]),
      .W          (w_s),
      .J          (j_s),
      .Cost       (cost_s),
      .busy       (busy_s),
      .Valid      (valid_s),
      .MinCost    (min_s),
      .MatchCount (cnt_s),
      .BestAssign (best_s)
    );

    assign w_v[g]     = 64'(w_s);
    assign j_v[g]     = 64'(j_s);
    assign min_v[g]   = 64'(min_s);
    assign cnt_v[g]   = 64'(cnt_s);
    assign best_v[g]  = 64'(best_s);
    assign busy_v[g]  = busy_s;
    assign valid_v[g] = valid_s;
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: pops one expectation on every rising Valid.
  initial begin
    logic vd [NDUT];
    exp_t e;
    for (int k = 0; k < NDUT; k++) vd[k] = 1'b0;
    forever begin
      @(negedge CLK);
      for (int k = 0; k < NDUT; k++) begin
        if (valid_v[k] && !vd[k]) begin
          done_cyc[k] = cyc;
          check($sformatf("dut%0d_result_expected", k), 64'(exp_q[k].size() != 0), 64'd1);
          if (exp_q[k].size() != 0) begin
            e = exp_q[k].pop_front();
            check($sformatf("dut%0d_busy_at_valid", k), 64'(busy_v[k]), 64'd0);
            check($sformatf("dut%0d_MinCost", k), min_v[k], e.min_cost);
            check($sformatf("dut%0d_MatchCount", k), cnt_v[k], e.count);
            check($sformatf("dut%0d_BestAssign", k), best_v[k], e.best);
          end
        end
        vd[k] = valid_v[k];
      end
    end
  end

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < NDUT; k++) s += exp_q[k].size();
    return s;
  endfunction

  task automatic wait_drain(input string tag, input int budget);
    int c = 0;
    while (pending() != 0 && c < budget) begin
      @(negedge CLK);
      c++;
    end
    check({tag, "_all_results_seen"}, 64'(pending()), 64'd0);
  endtask

  task automatic check_reset_state(input int g, input string tag);
    check($sformatf("%s_busy", tag), 64'(busy_v[g]), 64'd0);
    check($sformatf("%s_Valid", tag), 64'(valid_v[g]), 64'd0);
    check($sformatf("%s_MinCost", tag), min_v[g], all_ones(g));
    check($sformatf("%s_MatchCount", tag), cnt_v[g], 64'd0);
    check($sformatf("%s_BestAssign", tag), best_v[g], 64'd0);
    check($sformatf("%s_W", tag), w_v[g], 64'd0);
    check($sformatf("%s_J", tag), j_v[g], 64'd0);
  endtask

  task automatic pulse_start(input int g);
    start_v[g]   = 1'b1;
    start_cyc[g] = cyc;
    @(negedge CLK);
    start_v[g]   = 1'b0;
  endtask

  exp_t e_a, e_b, e_c, e_d, e_e, e_rand;
  int   lat_a0, c;

  initial begin
    e_a    = mk(0, 1, 'hE4);
    e_b    = mk(1, 1, 'h06);
    e_c    = mk(5, 1, 'h1);
    e_d    = mk(6, 720, 'h2C688);
    e_e    = mk(6, 255, 'h2C688);
    e_rand = model(5);

    RST = 1'b1;
    for (int k = 0; k < NDUT; k++) start_v[k] = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_state(0, "rst_n4");
    check_reset_state(3, "rst_n6");
    RST = 1'b0;
    @(negedge CLK);

    // All shapes except N=2 solved concurrently.
    exp_q[0].push_back(e_a);
    exp_q[1].push_back(e_b);
    exp_q[3].push_back(e_d);
    exp_q[4].push_back(e_e);
    exp_q[5].push_back(e_rand);
    exp_q[6].push_back(e_rand);
    for (int k = 0; k < NDUT; k++) begin
      if (k != 2) begin
        start_v[k]   = 1'b1;
        start_cyc[k] = cyc;
      end
    end
    @(negedge CLK);
    for (int k = 0; k < NDUT; k++) start_v[k] = 1'b0;
    check("n4_busy_after_start", 64'(busy_v[0]), 64'd1);
    wait_drain("first_solve", 40000);
    lat_a0 = done_cyc[0] - start_cyc[0];
    check("prune_fewer_cycles", 64'(done_cyc[6] - start_cyc[6] < done_cyc[5] - start_cyc[5]), 64'd1);

    // Results hold after DONE; a new start drops Valid; starts while busy are ignored.
    repeat (3) @(negedge CLK);
    check("n4_hold_Valid", 64'(valid_v[0]), 64'd1);
    check("n4_hold_MinCost", min_v[0], 64'd0);
    check("n4_hold_BestAssign", best_v[0], 64'hE4);
    exp_q[0].push_back(e_a);
    pulse_start(0);
    check("n4_rerun_Valid_drop", 64'(valid_v[0]), 64'd0);
    check("n4_rerun_busy", 64'(busy_v[0]), 64'd1);
    c = start_cyc[0];
    repeat (4) @(negedge CLK);
    pulse_start(0);
    repeat (30) @(negedge CLK);
    pulse_start(0);
    start_cyc[0] = c;
    check("n4_busy_during_ignored_start", 64'(busy_v[0]), 64'd1);
    wait_drain("rerun", 2000);
    check("n4_rerun_latency", 64'(done_cyc[0] - start_cyc[0]), 64'(lat_a0));

    // N=2: a start presented in the DONE cycle must be dropped.
    exp_q[2].push_back(e_c);
    pulse_start(2);
    c = 0;
    while (!valid_v[2] && c < 200) begin
      @(negedge CLK);
      c++;
    end
    check("n2_done_reached", 64'(valid_v[2]), 64'd1);
    start_v[2] = 1'b1;
    @(negedge CLK);
    start_v[2] = 1'b0;
    check("n2_start_in_done_busy", 64'(busy_v[2]), 64'd0);
    check("n2_start_in_done_Valid", 64'(valid_v[2]), 64'd1);
    @(negedge CLK);
    check("n2_idle_after_done_busy", 64'(busy_v[2]), 64'd0);
    wait_drain("n2", 10);

    // Reset in the middle of a READ pass, then a clean solve.
    pulse_start(0);
    c = 0;
    while (w_v[0] != 64'd1 && c < 20) begin
      @(negedge CLK);
      c++;
    end
    check("n4_reached_read", w_v[0], 64'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_reset_state(0, "midrun_rst");
    exp_q[0].push_back(e_a);
    pulse_start(0);
    wait_drain("after_rst", 2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
